// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 writeback stage: widths, condition-code
// encodings, source ids and the accepted-result descriptor.
package lc3_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam int NREG      = 8;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    // Which producer a grant went to; the arbiter remembers the last one.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // One result as presented by either producer.
    typedef struct packed {
        logic [REG_IDX_W-1:0] dst;
        logic [DATA_W-1:0]    value;
        logic                 setcc;
    } wb_res_t;

    // Condition code of a result: sign bit first, then zero, else positive.
    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
        if (v[DATA_W-1])
            return NZP_N;
        else if (v == '0)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

// File: rtl/lc3_wb_arbiter.sv
// Two-way round-robin arbiter between the ALU and load result paths.
// Grants are combinational from the requests and the last-grant pointer;
// a lone requester always wins, a collision goes to the one not served last.
module lc3_wb_arbiter
    import lc3_pkg::*;
(
    input  logic clk,
    input  logic rst_bar,
    input  logic i_req_alu,
    input  logic i_req_mem,
    output logic o_gnt_alu,
    output logic o_gnt_mem
);

    wb_src_e r_last;

    // Grant decode: on contention the pointer selects the other source.
    always_comb begin
        o_gnt_alu = i_req_alu & (~i_req_mem | (r_last == SRC_MEM));
        o_gnt_mem = i_req_mem & (~i_req_alu | (r_last == SRC_ALU));
    end

    // Remember who was served; pointer starts at ALU so the first collision goes to MEM.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar)
            r_last <= SRC_ALU;
        else if (o_gnt_mem)
            r_last <= SRC_MEM;
        else if (o_gnt_alu)
            r_last <= SRC_ALU;
    end

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: sole writer of the register file and NZP.
// Accepts ALU / load results round-robin, registers one result per cycle
// into an output slot that drives the register-file write port, and keeps
// a pending-write scoreboard for decode hazard stalls.
module lc3_writeback #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              issue_valid,
    input  logic [2:0]        issue_dst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [2:0]        alu_dst,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              alu_setcc,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [2:0]        mem_dst,
    input  logic [DATA_W-1:0] mem_value,
    input  logic              mem_setcc,
    output logic [2:0]        regw,
    output logic              we,
    output logic [DATA_W-1:0] regw_value,
    output logic [2:0]        nzp,
    output logic [NREG-1:0]   pending,
    output logic              err
);

    import lc3_pkg::*;

    logic            w_gnt_alu;
    logic            w_gnt_mem;
    logic            w_acc;
    wb_res_t         w_res;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic            w_err_issue;
    logic            w_err_res;

    logic                 r_we;
    logic [REG_IDX_W-1:0] r_regw;
    logic [DATA_W-1:0]    r_value;
    logic                 r_setcc;
    logic [2:0]           r_nzp;
    logic [NREG-1:0]      r_pending;
    logic                 r_err;

    lc3_wb_arbiter u_arb (
        .clk       (clk),
        .rst_bar   (rst_bar),
        .i_req_alu (alu_valid),
        .i_req_mem (mem_valid),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_mem (w_gnt_mem)
    );

    // Readies are the grants, forced low while reset is held.
    always_comb begin
        alu_ready = w_gnt_alu & rst_bar;
        mem_ready = w_gnt_mem & rst_bar;
        w_acc     = alu_ready | mem_ready;
        w_res     = mem_ready ? '{dst: mem_dst, value: mem_value, setcc: mem_setcc}
                              : '{dst: alu_dst, value: alu_value, setcc: alu_setcc};
    end

    // Scoreboard set/clear masks and the two protocol-violation detectors.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid)
            w_set[issue_dst] = 1'b1;
        if (r_we)
            w_clr[r_regw] = 1'b1;
        w_err_issue = issue_valid & r_pending[issue_dst] & ~w_clr[issue_dst];
        w_err_res   = w_acc & ~r_pending[w_res.dst];
    end

    // Output slot: drains every cycle; index/data only reload on acceptance.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_we    <= 1'b0;
            r_regw  <= '0;
            r_value <= '0;
            r_setcc <= 1'b0;
        end else begin
            r_we <= w_acc;
            if (w_acc) begin
                r_regw  <= w_res.dst;
                r_value <= w_res.value;
                r_setcc <= w_res.setcc;
            end
        end
    end

    // Condition codes follow the slot's write when it asks for it.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar)
            r_nzp <= NZP_Z;
        else if (r_we && r_setcc)
            r_nzp <= nzp_of(r_value);
    end

    // Pending writes: a new issue outranks a retiring write to the same index.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clr) | w_set;
    end

    // Sticky protocol-violation flag; the offending operation still proceeds.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar)
            r_err <= 1'b0;
        else if (w_err_issue || w_err_res)
            r_err <= 1'b1;
    end

    assign we         = r_we;
    assign regw       = r_regw;
    assign regw_value = r_value;
    assign nzp        = r_nzp;
    assign pending    = r_pending;
    assign err        = r_err;

endmodule

// File: tb/tb_lc3_writeback.sv
// Bench for lc3_writeback: a negedge monitor carries a reference model and
// a scoreboard queue of expected slot contents; directed sequences add
// fixed-value checks for the interesting scenarios.
module tb_lc3_writeback;

    logic        clk = 1'b0;
    logic        rst_bar = 1'b0;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_dst = '0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [2:0]  alu_dst = '0;
    logic [15:0] alu_value = '0;
    logic        alu_setcc = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [2:0]  mem_dst = '0;
    logic [15:0] mem_value = '0;
    logic        mem_setcc = 1'b0;
    logic [2:0]  regw;
    logic        we;
    logic [15:0] regw_value;
    logic [2:0]  nzp;
    logic [7:0]  pending;
    logic        err;

    lc3_writeback dut (
        .clk         (clk),
        .rst_bar     (rst_bar),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_dst     (alu_dst),
        .alu_value   (alu_value),
        .alu_setcc   (alu_setcc),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_dst     (mem_dst),
        .mem_value   (mem_value),
        .mem_setcc   (mem_setcc),
        .regw        (regw),
        .we          (we),
        .regw_value  (regw_value),
        .nzp         (nzp),
        .pending     (pending),
        .err         (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_nzp(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0) return 3'b010;
        return 3'b001;
    endfunction

    typedef struct {
        logic        we;
        logic [2:0]  regw;
        logic [15:0] val;
        logic        setcc;
    } exp_t;

    exp_t       sb[$];
    logic       m_ptr;
    logic [7:0] m_pend;
    logic [2:0] m_nzp;
    logic       m_err;

    // Reference model + scoreboard, evaluated mid-cycle when everything is stable.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        logic ga, gm, acc;
        logic [2:0] ad;
        logic [7:0] clr, set;
        if (!rst_bar) begin
            chk("rst_alu_ready", alu_ready, 1'b0);
            chk("rst_mem_ready", mem_ready, 1'b0);
            chk("rst_we", we, 1'b0);
            m_ptr  = 1'b0;
            m_pend = 8'h0;
            m_nzp  = 3'b010;
            m_err  = 1'b0;
            sb.delete();
            n.we = 1'b0; n.regw = '0; n.val = '0; n.setcc = 1'b0;
            sb.push_back(n);
        end else begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
                e.we = 1'b0; e.regw = '0; e.val = '0; e.setcc = 1'b0;
            end else begin
                e = sb.pop_front();
            end
            chk("we", we, e.we);
            if (e.we) begin
                chk("regw", regw, e.regw);
                chk("regw_value", regw_value, e.val);
            end
            chk("nzp", nzp, m_nzp);
            chk("pending", pending, m_pend);
            chk("err", err, m_err);
            ga = alu_valid && (!mem_valid || m_ptr);
            gm = mem_valid && (!alu_valid || !m_ptr);
            chk("alu_ready", alu_ready, ga);
            chk("mem_ready", mem_ready, gm);
            acc = ga || gm;
            ad  = gm ? mem_dst : alu_dst;
            n.we    = acc;
            n.regw  = ad;
            n.val   = gm ? mem_value : alu_value;
            n.setcc = gm ? mem_setcc : alu_setcc;
            sb.push_back(n);
            clr = e.we ? (8'h1 << e.regw) : 8'h0;
            set = issue_valid ? (8'h1 << issue_dst) : 8'h0;
            if (issue_valid && m_pend[issue_dst] && !clr[issue_dst]) m_err = 1'b1;
            if (acc && !m_pend[ad]) m_err = 1'b1;
            m_pend = (m_pend & ~clr) | set;
            if (e.we && e.setcc) m_nzp = ref_nzp(e.val);
            if (gm) m_ptr = 1'b1;
            else if (ga) m_ptr = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] d);
        issue_valid = 1'b1;
        issue_dst   = d;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic rst_pulse();
        rst_bar = 1'b0;
        tick();
        rst_bar = 1'b1;
        tick();
    endtask

    // Present one result and hold it until accepted (bounded wait).
    task automatic send(input bit is_mem, input logic [2:0] d, input logic [15:0] v, input logic s);
        bit ok = 1'b0;
        if (is_mem) begin
            mem_valid = 1'b1; mem_dst = d; mem_value = v; mem_setcc = s;
        end else begin
            alu_valid = 1'b1; alu_dst = d; alu_value = v; alu_setcc = s;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (is_mem ? mem_ready : alu_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk(is_mem ? "mem_accept" : "alu_accept", ok, 1'b1);
        tick();
        if (is_mem) mem_valid = 1'b0;
        else        alu_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst_bar = 1'b1;
        tick();

        // Issue R3, ALU writes 8000 with setcc.
        issue(3'd3);
        alu_valid = 1'b1; alu_dst = 3'd3; alu_value = 16'h8000; alu_setcc = 1'b1;
        @(negedge clk);
        chk("t2_alu_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t2_we", we, 1'b1);
        chk("t2_regw", regw, 3'd3);
        chk("t2_value", regw_value, 16'h8000);
        @(negedge clk);
        chk("t2_nzp", nzp, 3'b100);
        chk("t2_pend3", pending[3], 1'b0);
        tick();

        // Reset mid-stream with both sources valid.
        alu_valid = 1'b1; alu_dst = 3'd1; alu_value = 16'h1234; alu_setcc = 1'b1;
        mem_valid = 1'b1; mem_dst = 3'd2; mem_value = 16'h0005; mem_setcc = 1'b0;
        rst_bar = 1'b0;
        @(negedge clk);
        chk("t1_alu_ready", alu_ready, 1'b0);
        chk("t1_mem_ready", mem_ready, 1'b0);
        chk("t1_we", we, 1'b0);
        chk("t1_regw", regw, 3'd0);
        chk("t1_value", regw_value, 16'h0);
        chk("t1_nzp", nzp, 3'b010);
        chk("t1_pending", pending, 8'h0);
        chk("t1_err", err, 1'b0);
        tick();
        rst_bar = 1'b1;
        @(negedge clk);
        chk("t1_first_mem", mem_ready, 1'b1);
        chk("t1_first_alu", alu_ready, 1'b0);
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t1_second_alu", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        repeat (2) tick();
        rst_pulse();

        // Contention: MEM first, ALU second, consecutive writes.
        issue(3'd1);
        issue(3'd2);
        alu_valid = 1'b1; alu_dst = 3'd1; alu_value = 16'h0000; alu_setcc = 1'b1;
        mem_valid = 1'b1; mem_dst = 3'd2; mem_value = 16'h0005; mem_setcc = 1'b1;
        @(negedge clk);
        chk("t3_mem_first", mem_ready, 1'b1);
        chk("t3_alu_wait", alu_ready, 1'b0);
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("t3_alu_second", alu_ready, 1'b1);
        chk("t3_w1_regw", regw, 3'd2);
        chk("t3_w1_value", regw_value, 16'h0005);
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("t3_w2_we", we, 1'b1);
        chk("t3_w2_regw", regw, 3'd1);
        chk("t3_nzp_mid", nzp, 3'b001);
        @(negedge clk);
        chk("t3_nzp_final", nzp, 3'b010);
        tick();

        // setcc=0 must leave NZP alone.
        issue(3'd7);
        send(1'b0, 3'd7, 16'h8000, 1'b1);
        repeat (2) @(negedge clk);
        chk("t6_nzp_pre", nzp, 3'b100);
        tick();
        issue(3'd0);
        send(1'b1, 3'd0, 16'h0001, 1'b0);
        @(negedge clk);
        chk("t6_we", we, 1'b1);
        chk("t6_regw", regw, 3'd0);
        chk("t6_value", regw_value, 16'h0001);
        @(negedge clk);
        chk("t6_nzp_kept", nzp, 3'b100);
        tick();

        // Same-cycle set and clear on R4: set wins, no error.
        issue(3'd4);
        alu_valid = 1'b1; alu_dst = 3'd4; alu_value = 16'h0007; alu_setcc = 1'b0;
        @(negedge clk);
        chk("t4_ready", alu_ready, 1'b1);
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_dst = 3'd4;
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("t4_pend4", pending[4], 1'b1);
        chk("t4_err", err, 1'b0);
        tick();
        send(1'b0, 3'd4, 16'h0009, 1'b0);
        repeat (2) @(negedge clk);
        chk("t4_pend4_clr", pending[4], 1'b0);
        tick();

        // Back-to-back contention burst, alternating sources.
        for (int r = 1; r <= 6; r++) issue(3'(r));
        fork
            begin
                send(1'b0, 3'd1, 16'($urandom), 1'b1);
                send(1'b0, 3'd3, 16'($urandom), 1'b1);
                send(1'b0, 3'd5, 16'($urandom), 1'b1);
            end
            begin
                send(1'b1, 3'd2, 16'($urandom), 1'b1);
                send(1'b1, 3'd4, 16'($urandom), 1'b1);
                send(1'b1, 3'd6, 16'($urandom), 1'b1);
            end
        join
        repeat (3) tick();
        @(negedge clk);
        chk("burst_pending", pending, 8'h0);
        chk("burst_err", err, 1'b0);
        tick();

        // Double issue of R5 trips the sticky error.
        issue(3'd5);
        issue(3'd5);
        @(negedge clk);
        chk("t5_err_set", err, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        chk("t5_err_sticky", err, 1'b1);
        tick();

        // Result to a non-pending register also trips it.
        rst_pulse();
        @(negedge clk);
        chk("t5_err_clr", err, 1'b0);
        tick();
        send(1'b0, 3'd6, 16'h0003, 1'b0);
        @(negedge clk);
        chk("t5_err_res", err, 1'b1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_writeback.md
# lc3_writeback

Writeback stage for the LC-3 core: the single writer of the 8×16-bit general register file and of the NZP condition-code register. It accepts completed results from the ALU path and the memory-load path through valid/ready handshakes, arbitrates between them round-robin, and drives the register file write port one cycle after acceptance. It also keeps an 8-bit pending-write scoreboard that decode reads to stall on RAW/WAW hazards.

## Interface
- DATA_W, 16, result and register width
- NREG, 8, number of general registers (index width 3)

- clk  in  1  system clock, all state on rising edge
- rst_bar  in  1  asynchronous active-low reset
- issue_valid  in  1  decode issued an instruction that writes a register
- issue_dst  in  3  destination register of that instruction
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_dst  in  3  ALU destination register
- alu_value  in  16  ALU result
- alu_setcc  in  1  result updates NZP
- mem_valid / mem_ready / mem_dst / mem_value / mem_setcc  same as ALU group, load path
- regw  out  3  register file write index
- we  out  1  register file write enable
- regw_value  out  16  register file write data
- nzp  out  3  condition codes {N,Z,P}
- pending  out  8  bit i set = write to Ri outstanding
- err  out  1  sticky protocol-violation flag

## Operation
- Acceptance: a source transfers when valid && ready in the same cycle. Sources hold valid, dst, value and setcc stable until ready.
- Arbitration: at most one transfer per cycle.
  - Only one source valid: that source is granted.
  - Both valid: the source not granted most recently wins. The last-grant pointer resets to ALU, so the first collision goes to MEM.
  - ready is combinational from the valids and the pointer. ready is never asserted without the matching valid.
- Output slot: one register stage holding {we, regw, regw_value, setcc}. It loads the accepted result, or loads we=0 when nothing is accepted. It drains every cycle, so acceptance never stalls for output back-pressure.
- NZP: updated when the slot holds we=1 and setcc=1. The new value is one-hot:
  - 100 if regw_value[15] is 1
  - 010 if regw_value is 0
  - 001 otherwise
  - Any other nzp value is unreachable.
- Scoreboard:
  - issue_valid sets pending[issue_dst].
  - A slot write (we=1) clears pending[regw].
  - Set and clear of the same index in the same cycle: set wins, because the new writer is outstanding.
- err (sticky until reset) is set when either of these occurs:
  - issue_valid targets an index whose pending bit is already set and is not being cleared that cycle.
  - An accepted result targets an index whose pending bit is clear.
- The offending operation still executes normally.

## Timing
- Reset values: we=0, regw=0, regw_value=0, nzp=010, pending=0, err=0, pointer=ALU. alu_ready and mem_ready are 0 while rst_bar is low.
- Latency:
  - Accepted at edge N.
  - we/regw/regw_value valid during cycle N+1.
  - Register file captures at edge N+2.
  - nzp and pending clear update at the same edge N+2.
- Reset mid-operation clears the slot. A result accepted in the cycle reset asserts is dropped.
- Back-to-back: sustained one write per cycle, alternating sources under contention.
- Decode reads pending combinationally from flops; no combinational path from issue_* to pending.

## Structure
- Shared package lc3_pkg holds:
  - DATA_W and REG_IDX_W=3
  - NZP constants: NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001
  - a function returning the NZP code of a 16-bit value
- Sub-module lc3_wb_arbiter: two-way round-robin arbiter. Inputs are two valids; outputs are two grants; internally it holds the last-grant pointer. The top level holds the slot, NZP and scoreboard.

## Test plan
- Reset with rst_bar low mid-stream, all sources valid → every output at its reset value, including nzp=010, and both readys at 0. After release, the first grant follows the arbitration rules with the pointer at ALU.
- Issue R3; next cycle ALU valid with dst=3, value=16'h8000, setcc=1 → alu_ready in the accept cycle; next cycle we=1, regw=3, regw_value=8000. After that edge, nzp=100 and pending[3]=0.
- Issue R1 and R2; ALU (dst=1, value 0) and MEM (dst=2, value 5) valid together for 2 cycles → MEM granted first, ALU second. Writes occur on consecutive cycles. Final nzp=010 (ALU, value 0, last).
- Slot writes R4 while issue_valid with issue_dst=4 in the same cycle → pending[4] stays 1 and err stays 0.
- Issue R5 twice with no intervening write → err=1 and remains 1. A result to R6 with pending[6]=0 also sets err.
- MEM result with setcc=0, value 16'h0001, while nzp=100 → register written, nzp still 100.
